// File: rtl/lif_sweep_scheduler.sv
// Sweeps N_NEURONS LIF neurons through one shared external datapath per tick, with
// double-buffered synaptic accumulators. Define LIF_SCHED_SPIKE_CNT_EN to add spike_count.
module lif_sweep_scheduler #(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  output logic                    busy,
  output logic                    done,
  output logic                    tick_overrun,
  input  logic                    syn_valid,
  input  logic [IDX_W-1:0]        syn_idx,
  input  logic signed [15:0]      syn_data,
  output logic signed [15:0]      dp_vs,
  output logic signed [15:0]      dp_vd,
  output logic signed [15:0]      dp_syn,
  input  logic signed [15:0]      dp_next_vs,
  input  logic signed [15:0]      dp_next_vd,
  input  logic                    dp_spike,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  input  logic                    spike_ready
`ifdef LIF_SCHED_SPIKE_CNT_EN
  ,
  output logic [IDX_W:0]          spike_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_wbank;
  logic                  w_rbank;
  logic signed [15:0]    r_vs  [N_NEURONS];
  logic signed [15:0]    r_vd  [N_NEURONS];
  logic signed [15:0]    r_acc [2][N_NEURONS];
  logic                  r_spike_valid;
  logic [IDX_W-1:0]      r_spike_idx;
  logic                  r_overrun;

  logic                  w_run;
  logic                  w_eval;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_drop;
  logic signed [15:0]    w_syn_cur;
  logic signed [16:0]    w_syn_sum;
  logic signed [15:0]    w_syn_sat;

  assign w_rbank = ~r_wbank;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_run       = (r_state == S_RUN);
    // A pending spike the router will not take this cycle freezes the sweep.
    w_eval      = w_run && !(r_spike_valid && !spike_ready);
    w_last      = (r_idx == IDX_W'(N_NEURONS - 1));
    w_accept    = (r_state == S_IDLE) && tick;
    w_drop      = (r_state != S_IDLE) && tick;
    case (r_state)
      S_IDLE:  if (tick) w_state_nxt = S_RUN;
      S_RUN:   if (w_eval && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands stay visible through stall cycles so the datapath result is stable when it lands.
  always_comb begin
    dp_vs  = '0;
    dp_vd  = '0;
    dp_syn = '0;
    if (w_run) begin
      dp_vs  = r_vs[r_idx];
      dp_vd  = r_vd[r_idx];
      dp_syn = r_acc[w_rbank][r_idx];
    end
  end

  always_comb begin
    w_syn_cur = r_acc[r_wbank][syn_idx];
    w_syn_sum = {w_syn_cur[15], w_syn_cur} + {syn_data[15], syn_data};
    if (w_syn_sum[16] != w_syn_sum[15]) begin
      w_syn_sat = w_syn_sum[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      w_syn_sat = w_syn_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wbank       <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
      r_overrun     <= 1'b0;
      // NOTE: the membrane and accumulator arrays are reset explicitly because a reset
      // mid-sweep must leave every neuron at rest, not just the control state.
      for (int i = 0; i < N_NEURONS; i++) begin
        r_vs[i]     <= '0;
        r_vd[i]     <= '0;
        r_acc[0][i] <= '0;
        r_acc[1][i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block sees
      // pre-edge values regardless of statement order.
      r_state   <= w_state_nxt;
      r_overrun <= w_drop;

      if (w_accept) begin
        r_wbank <= ~r_wbank;
        r_idx   <= '0;
      end else if (w_eval) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end

      if (w_eval) begin
        r_vs[r_idx]           <= dp_next_vs;
        r_vd[r_idx]           <= dp_next_vd;
        r_acc[w_rbank][r_idx] <= '0;
      end

      // Writes and the evaluate-clear always target opposite banks.
      if (syn_valid) begin
        r_acc[r_wbank][syn_idx] <= w_syn_sat;
      end

      if (w_eval && dp_spike) begin
        r_spike_valid <= 1'b1;
        r_spike_idx   <= r_idx;
      end else if (r_spike_valid && spike_ready) begin
        r_spike_valid <= 1'b0;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign tick_overrun = r_overrun;
  assign spike_valid  = r_spike_valid;
  assign spike_idx    = r_spike_idx;

`ifdef LIF_SCHED_SPIKE_CNT_EN
  logic [IDX_W:0] r_spk_cnt;
  logic [IDX_W:0] r_spike_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spk_cnt     <= '0;
      r_spike_count <= '0;
    end else begin
      if (w_accept) begin
        r_spk_cnt <= '0;
      end else if (w_eval && dp_spike) begin
        r_spk_cnt <= r_spk_cnt + (IDX_W + 1)'(1);
      end
      if (r_state == S_DONE) begin
        r_spike_count <= r_spk_cnt;
      end
    end
  end

  assign spike_count = r_spike_count;
`endif

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Self-checking bench for lif_sweep_scheduler: a simple LIF datapath (LEAK=1, V_THRESH=10,
// G_C=1 as a halving shift) plus a per-cycle behavioural model of the sweep.
module tb_lif_sweep_scheduler;

  localparam int N        = 16;
  localparam int IDX_W    = 4;
  localparam int LEAK     = 1;
  localparam int V_THRESH = 10;
  localparam int G_C      = 1;
  localparam int P_IDLE   = 0;
  localparam int P_RUN    = 1;
  localparam int P_DONE   = 2;

  typedef struct packed {
    logic signed [15:0] vs;
    logic signed [15:0] vd;
    logic               spk;
  } dp_res_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tick;
  logic                 busy;
  logic                 done;
  logic                 tick_overrun;
  logic                 syn_valid;
  logic [IDX_W-1:0]     syn_idx;
  logic signed [15:0]   syn_data;
  logic signed [15:0]   dp_vs;
  logic signed [15:0]   dp_vd;
  logic signed [15:0]   dp_syn;
  logic                 spike_valid;
  logic [IDX_W-1:0]     spike_idx;
  logic                 spike_ready;
  dp_res_t              w_dp;
`ifdef LIF_SCHED_SPIKE_CNT_EN
  logic [IDX_W:0]       spike_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_ovr    = 0;
  bit chk_en   = 1'b0;
  int delivered[$];

  // Model state
  int m_vs [N];
  int m_vd [N];
  int m_acc [2][N];
  int m_ph, m_idx, m_spk_i, m_cnt, m_scnt;
  bit m_wbank, m_spk_v, m_ovr, mt_ev;
  dp_res_t mt_r;

  always #5 clk = ~clk;

  lif_sweep_scheduler #(.N_NEURONS(N), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .busy         (busy),
    .done         (done),
    .tick_overrun (tick_overrun),
    .syn_valid    (syn_valid),
    .syn_idx      (syn_idx),
    .syn_data     (syn_data),
    .dp_vs        (dp_vs),
    .dp_vd        (dp_vd),
    .dp_syn       (dp_syn),
    .dp_next_vs   (w_dp.vs),
    .dp_next_vd   (w_dp.vd),
    .dp_spike     (w_dp.spk),
    .spike_valid  (spike_valid),
    .spike_idx    (spike_idx),
    .spike_ready  (spike_ready)
`ifdef LIF_SCHED_SPIKE_CNT_EN
    ,
    .spike_count  (spike_count)
`endif
  );

  function automatic int clamp(input int x);
    return (x < 0) ? 0 : ((x > 32767) ? 32767 : x);
  endfunction

  function automatic int sat16(input int x);
    return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
  endfunction

  // Two-compartment LIF step: dendrite couples into soma, both leak, soma resets on spike.
  function automatic dp_res_t lif_dp(input int vs, input int vd, input int syn);
    dp_res_t r;
    int coup, nvd, raw;
    coup  = (vd - vs) >>> G_C;
    nvd   = clamp(vd + syn - LEAK - coup);
    raw   = clamp(vs + coup - LEAK);
    r.spk = (raw >= V_THRESH);
    r.vd  = 16'(nvd);
    r.vs  = r.spk ? 16'sd0 : 16'(raw);
    return r;
  endfunction

  assign w_dp = lif_dp(int'(dp_vs), int'(dp_vd), int'(dp_syn));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_vs[i] = 0; m_vd[i] = 0; m_acc[0][i] = 0; m_acc[1][i] = 0;
    end
    m_ph = P_IDLE; m_idx = 0; m_wbank = 1'b0; m_spk_v = 1'b0; m_spk_i = 0;
    m_ovr = 1'b0; m_cnt = 0; m_scnt = 0;
  endtask

  task automatic model_step();
    mt_ev = (m_ph == P_RUN) && !(m_spk_v && !spike_ready);
    mt_r  = '0;
    if (mt_ev) mt_r = lif_dp(m_vs[m_idx], m_vd[m_idx], m_acc[!m_wbank][m_idx]);
    if (syn_valid) m_acc[m_wbank][syn_idx] = sat16(m_acc[m_wbank][syn_idx] + int'(syn_data));
    m_ovr = tick && (m_ph != P_IDLE);
    if (mt_ev) begin
      m_vs[m_idx] = int'(mt_r.vs);
      m_vd[m_idx] = int'(mt_r.vd);
      m_acc[!m_wbank][m_idx] = 0;
    end
    if (mt_ev && mt_r.spk) begin
      m_spk_v = 1'b1; m_spk_i = m_idx; m_cnt++;
    end else if (m_spk_v && spike_ready) begin
      m_spk_v = 1'b0;
    end
    case (m_ph)
      P_IDLE: if (tick) begin
        m_ph = P_RUN; m_wbank = !m_wbank; m_idx = 0; m_cnt = 0;
      end
      P_RUN: if (mt_ev) begin
        if (m_idx == N - 1) begin m_ph = P_DONE; m_idx = 0; end
        else m_idx++;
      end
      default: begin m_ph = P_IDLE; m_scnt = m_cnt; end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else      model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model, plus event capture for the directed checks.
  initial forever begin
    @(negedge clk);
    if (rst && chk_en) begin
      check("status", {busy, done, tick_overrun},
            {(m_ph != P_IDLE), (m_ph == P_DONE), m_ovr});
      if (m_ph == P_RUN)
        check("dp", {dp_vs, dp_vd, dp_syn},
              {16'(m_vs[m_idx]), 16'(m_vd[m_idx]), 16'(m_acc[!m_wbank][m_idx])});
      else
        check("dp", {dp_vs, dp_vd, dp_syn}, 48'd0);
      check("spike", {spike_valid, spike_valid ? spike_idx : 4'd0},
            {m_spk_v, m_spk_v ? 4'(m_spk_i) : 4'd0});
`ifdef LIF_SCHED_SPIKE_CNT_EN
      check("spike_count", spike_count, 64'(m_scnt));
`endif
      if (spike_valid && spike_ready) delivered.push_back(int'(spike_idx));
      if (tick_overrun) n_ovr++;
    end
  end

  task automatic syn_wr(input int idx, input int data);
    @(posedge clk); #1;
    syn_valid = 1'b1; syn_idx = 4'(idx); syn_data = 16'(data);
    @(posedge clk); #1;
    syn_valid = 1'b0;
  endtask

  task automatic pulse_tick(output int t);
    @(posedge clk); #1;
    tick = 1'b1; t = cyc;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin d = cyc; break; end
    end
    if (d < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    spike_ready = 1'b1;
    delivered.delete();
    n_ovr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d;
    bit seen;
    rst = 1'b0; tick = 1'b0; syn_valid = 1'b0; syn_idx = '0; syn_data = '0;
    spike_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", {busy, done, tick_overrun, spike_valid}, 4'd0);
    check("reset_dp", {dp_vs, dp_vd, dp_syn}, 48'd0);
    #2;
    rst = 1'b1;
    chk_en = 1'b1;

    // Sub-threshold single neuron and basic sweep latency
    syn_wr(3, 20);
    pulse_tick(t);
    wait_done(d);
    check("t1_done_latency", 64'(d - t), 64'd17);
    check("t1_vd3", 64'(m_vd[3]), 64'd19);
    check("t1_vs3", 64'(m_vs[3]), 64'd0);
    check("t1_no_spike", 64'(delivered.size()), 64'd0);

    // Charge then fire
    do_reset();
    syn_wr(5, 40);
    pulse_tick(t);
    wait_done(d);
    check("t2_vd5_first", 64'(m_vd[5]), 64'd39);
    check("t2_vs5_first", 64'(m_vs[5]), 64'd0);
    pulse_tick(t);
    wait_done(d);
    @(negedge clk);
    check("t2_spike_n", 64'(delivered.size()), 64'd1);
    if (delivered.size() > 0) check("t2_spike_idx", 64'(delivered[0]), 64'd5);
    check("t2_vs5", 64'(m_vs[5]), 64'd0);
    check("t2_vd5", 64'(m_vd[5]), 64'd19);
`ifdef LIF_SCHED_SPIKE_CNT_EN
    check("t2_spike_count", spike_count, 64'd1);
`endif

    // Backpressure: five stalled cycles delay done by five
    do_reset();
    syn_wr(2, 40);
    syn_wr(3, 40);
    pulse_tick(t);
    wait_done(d);
    pulse_tick(t);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (spike_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("t3_spike_seen", 64'(seen), 64'd1);
    check("t3_first_cycle", 64'(cyc - t), 64'd4);
    spike_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    spike_ready = 1'b1;
    wait_done(d);
    check("t3_done_latency", 64'(d - t), 64'd22);
    @(negedge clk);
    check("t3_spike_n", 64'(delivered.size()), 64'd2);
    if (delivered.size() == 2) begin
      check("t3_order0", 64'(delivered[0]), 64'd2);
      check("t3_order1", 64'(delivered[1]), 64'd3);
    end

    // Bank isolation: writes during the sweep only show up in the next one
    do_reset();
    pulse_tick(t);
    syn_valid = 1'b1; syn_idx = 4'd0; syn_data = 16'sd7;
    @(negedge clk);
    check("t4_syn0_this", 64'(dp_syn), 64'd0);
    repeat (16) begin @(posedge clk); #1; end
    syn_valid = 1'b0;
    wait_done(d);
    check("t4_acc_model", 64'(m_acc[m_wbank][0]), 64'd112);
    pulse_tick(t);
    @(negedge clk);
    check("t4_syn0_next", 64'(dp_syn), 64'd112);
    wait_done(d);

    // Saturation and overrun
    do_reset();
    syn_wr(1, 30000);
    syn_wr(1, 30000);
    syn_wr(4, -30000);
    syn_wr(4, -30000);
    check("t5_sat_pos", 64'(m_acc[0][1]), 64'd32767);
    check("t5_sat_neg", 64'(m_acc[0][4]), 64'(-32768));
    pulse_tick(t);
    @(negedge clk);
    @(negedge clk);
    check("t5_dp_syn1", 64'(dp_syn), 64'h7FFF);
    repeat (3) @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(negedge clk);
    check("t5_overrun_pulse", 64'(tick_overrun), 64'd1);
    wait_done(d);
    check("t5_done_latency", 64'(d - t), 64'd17);
    check("t5_overrun_n", 64'(n_ovr), 64'd1);

    // Reset in the middle of a sweep with a spike pending
    do_reset();
    syn_wr(7, 40);
    pulse_tick(t);
    wait_done(d);
    spike_ready = 1'b0;
    pulse_tick(t);
    repeat (8) begin @(posedge clk); #1; end
    check("t6_pending", 64'(spike_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_reset_status", {busy, done, tick_overrun, spike_valid}, 4'd0);
    check("t6_reset_dp", {dp_vs, dp_vd, dp_syn}, 48'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    spike_ready = 1'b1;
    delivered.delete();
    pulse_tick(t);
    wait_done(d);
    check("t6_done_latency", 64'(d - t), 64'd17);
    repeat (2) @(negedge clk);
    check("t6_no_spike", 64'(delivered.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
